// File: rtl/arm_irq_pkg.sv
// rtl/arm_irq_pkg.sv - shared constants and types for the ARM interrupt controller
package arm_irq_pkg;

    localparam logic [1:0] ADDR_PENDING = 2'd0;
    localparam logic [1:0] ADDR_MASK    = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_CTRL    = 2'd3;

    localparam int CTRL_GIE_BIT = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pulse_state_e;

endpackage

// File: rtl/irq_sync_edge.sv
// rtl/irq_sync_edge.sv - per-source synchroniser and rising-edge detector
module irq_sync_edge #(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    output logic [NUM_SRC-1:0] set_vec
);

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
    logic [NUM_SRC-1:0]                  prev_q, prev_d;
    // fill_q[k] becomes 1 once stage k carries post-reset data; the last bit
    // qualifies prev_q so a source already high at reset release is not an edge.
    logic [SYNC_STAGES:0]                fill_q, fill_d;

    // Next-state for the synchroniser chain, previous-value flop and fill tracker
    always_comb begin
        sync_d[0] = irq_src;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        fill_d = {fill_q[SYNC_STAGES-1:0], 1'b1};
    end

    // State registers, cleared asynchronously so in-flight edges are dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= '0;
            fill_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            fill_q <= fill_d;
        end
    end

    assign set_vec = fill_q[SYNC_STAGES] ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;

endmodule

// File: rtl/arm_irq_controller.sv
// rtl/arm_irq_controller.sv - interrupt aggregator with register port; ARM_IRQ_PULSE_EN selects pulse output
module arm_irq_controller
    import arm_irq_pkg::*;
#(
    parameter int NUM_SRC     = 16,
    parameter int SYNC_STAGES = 2,
    parameter int PULSE_LEN   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [1:0]         reg_addr,
    input  logic [15:0]        reg_wdata,
    output logic [15:0]        reg_rdata,
    output logic               reg_rvalid,
    output logic               irq_out
);

    // Register bits at or above NUM_SRC are forced to zero everywhere
    localparam logic [15:0] SRC_MASK = 16'((32'd1 << NUM_SRC) - 32'd1);

    if (NUM_SRC < 1 || NUM_SRC > 16 || SYNC_STAGES < 2 || PULSE_LEN < 1) begin : g_bad_param
        $error("arm_irq_controller: parameter out of range");
    end

    logic [NUM_SRC-1:0] set_vec;
    logic [15:0]        set16;
    logic [15:0]        w1c;

    logic [15:0] pending_q, pending_d;
    logic [15:0] mask_q, mask_d;
    logic        gie_q, gie_d;
    logic [15:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        irq_q, irq_d;

    irq_sync_edge #(
        .NUM_SRC     (NUM_SRC),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk     (clk),
        .rst     (rst),
        .irq_src (irq_src),
        .set_vec (set_vec)
    );

    assign set16 = 16'(set_vec);

    // Register file next-state: set beats W1C, STATUS is read-only, reads see pre-write values
    always_comb begin
        w1c       = '0;
        mask_d    = mask_q;
        gie_d     = gie_q;
        rdata_d   = rdata_q;
        rvalid_d  = reg_rd;
        if (reg_wr) begin
            case (reg_addr)
                ADDR_PENDING: w1c    = reg_wdata;
                ADDR_MASK:    mask_d = reg_wdata & SRC_MASK;
                ADDR_CTRL:    gie_d  = reg_wdata[CTRL_GIE_BIT];
                default:      ;
            endcase
        end
        pending_d = (set16 | (pending_q & ~w1c)) & SRC_MASK;
        if (reg_rd) begin
            case (reg_addr)
                ADDR_PENDING: rdata_d = pending_q;
                ADDR_MASK:    rdata_d = mask_q;
                ADDR_STATUS:  rdata_d = pending_q & mask_q;
                default:      rdata_d = 16'({gie_q} << CTRL_GIE_BIT);
            endcase
        end
    end

    // Register file and read-port flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            mask_q    <= '0;
            gie_q     <= 1'b0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
        end else begin
            pending_q <= pending_d;
            mask_q    <= mask_d;
            gie_q     <= gie_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

`ifdef ARM_IRQ_PULSE_EN
    localparam int CNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

    pulse_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic retrig_q, retrig_d;
    logic lvl_q, lvl_d;
    logic trigger;

    // Pulse FSM next-state: level rise is judged on next-state values so an edge
    // and the PENDING bit it sets count as one trigger, not two
    always_comb begin
        lvl_d    = gie_d & |(pending_d & mask_d);
        trigger  = (gie_q & |(set16 & mask_q)) | (lvl_d & ~lvl_q);
        state_d  = state_q;
        cnt_d    = cnt_q;
        retrig_d = retrig_q;
        case (state_q)
            IDLE: begin
                if (trigger) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (cnt_q == CNT_W'(PULSE_LEN - 1)) begin
                    state_d  = (retrig_q | trigger) ? GAP : IDLE;
                    retrig_d = 1'b0;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    retrig_d = retrig_q | trigger;
                end
            end
            GAP: begin
                state_d = PULSE;
                cnt_d   = '0;
            end
            default: state_d = IDLE;
        endcase
        irq_d = (state_d == PULSE);
    end

    // Pulse FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            retrig_q <= 1'b0;
            lvl_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retrig_q <= retrig_d;
            lvl_q    <= lvl_d;
        end
    end
`else
    // Level request: any enabled, unmasked pending source
    always_comb begin
        irq_d = gie_q & |(pending_q & mask_q);
    end
`endif

    // Registered interrupt output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign reg_rdata  = rdata_q;
    assign reg_rvalid = rvalid_q;
    assign irq_out    = irq_q;

endmodule

// File: tb/tb_arm_irq_controller.sv
// tb/tb_arm_irq_controller.sv - self-checking bench for arm_irq_controller
module tb_arm_irq_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] irq_src;
    logic        reg_wr;
    logic        reg_rd;
    logic [1:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata;
    logic        reg_rvalid;
    logic        irq_out;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [15:0] src;
        logic        wr;
        logic        rd;
        logic [1:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rexp;
        logic        ci;
        logic        ie;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] exp_q[$];

    arm_irq_controller #(
        .NUM_SRC     (16),
        .SYNC_STAGES (2),
        .PULSE_LEN   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .irq_src    (irq_src),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_rvalid (reg_rvalid),
        .irq_out    (irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Read scoreboard: every rvalid must match the oldest outstanding expectation
    always @(posedge clk) begin
        #1;
        if (reg_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 16'(reg_rvalid), 16'h0);
            end else begin
                check("rdata", reg_rdata, exp_q.pop_front());
            end
        end
    end

    function automatic void v(input logic [15:0] src, input logic wr, input logic rd,
                              input logic [1:0] addr, input logic [15:0] wdata,
                              input logic [15:0] rexp, input logic ci, input logic ie);
        vecs.push_back('{src, wr, rd, addr, wdata, rexp, ci, ie});
    endfunction

    task automatic run_vecs();
        foreach (vecs[i]) begin
            @(negedge clk);
            irq_src   = vecs[i].src;
            reg_wr    = vecs[i].wr;
            reg_rd    = vecs[i].rd;
            reg_addr  = vecs[i].addr;
            reg_wdata = vecs[i].wdata;
            if (vecs[i].rd) exp_q.push_back(vecs[i].rexp);
            @(posedge clk);
            #1;
`ifndef ARM_IRQ_PULSE_EN
            if (vecs[i].ci) check($sformatf("irq_step%0d", i), 16'(irq_out), 16'(vecs[i].ie));
`endif
        end
        vecs.delete();
        @(negedge clk);
        reg_wr = 1'b0;
        reg_rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = 16'h0001; reg_wr = 0; reg_rd = 0; reg_addr = 0; reg_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_irq", 16'(irq_out), 16'h0);
        check("rst_rvalid", 16'(reg_rvalid), 16'h0);
        check("rst_rdata", reg_rdata, 16'h0);
        rst = 1'b0;

        // src bit0 high across reset release: no PENDING
        for (int i = 0; i < 3; i++) v(16'h0001, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0001, 0, 1, 0, 0, 16'h0000, 1, 0);
        v(16'h0001, 0, 1, 2, 0, 16'h0000, 1, 0);
        v(16'h0001, 1, 0, 1, 16'h0004, 0, 1, 0);
        v(16'h0001, 1, 0, 3, 16'h0001, 0, 1, 0);
        v(16'h0001, 0, 1, 1, 0, 16'h0004, 1, 0);
        v(16'h0001, 0, 1, 3, 0, 16'h0001, 1, 0);
        // rise bit2: PENDING at edge 3, irq at edge 4, W1C drops irq
        v(16'h0005, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0005, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0005, 0, 1, 0, 0, 16'h0000, 1, 0);
        v(16'h0005, 0, 1, 0, 0, 16'h0004, 1, 1);
        v(16'h0005, 1, 0, 0, 16'h0004, 0, 1, 1);
        v(16'h0005, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0005, 0, 1, 0, 0, 16'h0000, 1, 0);
        // bit3 edge coincides with W1C of bit3: set wins
        v(16'h000D, 0, 0, 0, 0, 0, 1, 0);
        v(16'h000D, 0, 0, 0, 0, 0, 1, 0);
        v(16'h000D, 1, 0, 0, 16'h0008, 0, 1, 0);
        v(16'h000D, 0, 1, 0, 0, 16'h0008, 1, 0);
        v(16'h000D, 1, 0, 0, 16'h0008, 0, 1, 0);
        v(16'h000D, 0, 1, 0, 0, 16'h0000, 1, 0);
        // falling edges set nothing
        for (int i = 0; i < 4; i++) v(16'h0000, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0000, 0, 1, 0, 0, 16'h0000, 1, 0);
        // MASK=0, raise bits 0 and 1, then unmask bit1 (same-cycle read returns old)
        v(16'h0000, 1, 0, 1, 16'h0000, 0, 1, 0);
        for (int i = 0; i < 3; i++) v(16'h0003, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0003, 0, 1, 0, 0, 16'h0003, 1, 0);
        v(16'h0003, 0, 1, 2, 0, 16'h0000, 1, 0);
        v(16'h0003, 1, 1, 1, 16'h0002, 16'h0000, 1, 0);
        v(16'h0003, 0, 1, 2, 0, 16'h0002, 1, 1);
        v(16'h0003, 1, 0, 2, 16'hFFFF, 0, 1, 1);
        v(16'h0003, 0, 1, 2, 0, 16'h0002, 1, 1);
        v(16'h0003, 0, 1, 1, 0, 16'h0002, 1, 1);
        // GIE off then on; CTRL upper bits read 0
        v(16'h0003, 1, 0, 3, 16'hFFFE, 0, 1, 1);
        v(16'h0003, 0, 1, 3, 0, 16'h0000, 1, 0);
        v(16'h0003, 1, 0, 3, 16'hFFFF, 0, 1, 0);
        v(16'h0003, 0, 0, 0, 0, 0, 1, 1);
        v(16'h0003, 0, 1, 1, 0, 16'h0002, 1, 1);
        v(16'h0003, 1, 0, 3, 16'h0001, 0, 1, 1);
        v(16'h0003, 0, 0, 0, 0, 0, 1, 1);
        run_vecs();
        check("rdata_hold", reg_rdata, 16'h0002);

        // Asynchronous reset mid-operation
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst_irq", 16'(irq_out), 16'h0);
        check("async_rst_rdata", reg_rdata, 16'h0);
        check("async_rst_rvalid", 16'(reg_rvalid), 16'h0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) v(16'h0003, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0003, 0, 1, 0, 0, 16'h0000, 1, 0);
        v(16'h0003, 0, 1, 1, 0, 16'h0000, 1, 0);
        v(16'h0003, 0, 1, 3, 0, 16'h0000, 1, 0);
        for (int i = 0; i < 3; i++) v(16'h0007, 0, 0, 0, 0, 0, 1, 0);
        v(16'h0007, 0, 1, 0, 0, 16'h0004, 1, 0);
        run_vecs();

`ifdef ARM_IRQ_PULSE_EN
        v(16'h0000, 1, 0, 0, 16'hFFFF, 0, 0, 0);
        v(16'h0000, 1, 0, 1, 16'h0003, 0, 0, 0);
        v(16'h0000, 1, 0, 3, 16'h0001, 0, 0, 0);
        for (int i = 0; i < 3; i++) v(16'h0000, 0, 0, 0, 0, 0, 0, 0);
        run_vecs();
        check("pulse_idle", 16'(irq_out), 16'h0);
        // bit0 edge -> 8-cycle pulse; bit1 edge at pulse cycle 3 -> 1 low, then 8 more
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            irq_src = (i >= 3) ? 16'h0003 : 16'h0001;
            @(posedge clk); #1;
            check($sformatf("pulse_c%0d", i), 16'(irq_out),
                  16'(((i >= 2) && (i <= 9)) || ((i >= 11) && (i <= 18))));
        end
        v(16'h0000, 1, 0, 0, 16'hFFFF, 0, 0, 0);
        for (int i = 0; i < 4; i++) v(16'h0000, 0, 0, 0, 0, 0, 0, 0);
        run_vecs();
        irq_src = 16'h0001;
        repeat (6) @(posedge clk);
        #1;
        check("pulse_pre_rst", 16'(irq_out), 16'h1);
        #2;
        rst = 1'b1;
        #1;
        check("pulse_rst_irq", 16'(irq_out), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) v(16'h0001, 0, 0, 0, 0, 0, 0, 0);
        v(16'h0001, 0, 1, 0, 0, 16'h0000, 0, 0);
        run_vecs();
        check("pulse_after_rst", 16'(irq_out), 16'h0);
`endif

        repeat (3) @(negedge clk);
        check("sb_drain", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
